// File: rtl/prach_buffer_mc_if.sv
// prach_buffer_mc_if: sample stream, capture control, done handshake and read port of prach_buffer_mc.
interface prach_buffer_mc_if #(
    parameter int DW = 16,
    parameter int AW = 11,
    parameter int CW = 2
);
    logic [DW-1:0]   din_dr, din_di;
    logic            din_dv;
    logic [7:0]      din_chn;
    logic [15:0]     din_sample_k;
    logic            ctrl_enable;
    logic [15:0]     ctrl_time_offset;
    logic            done_req, done_bank, done_ack;
    logic            rd_bank, rd_en, rd_valid;
    logic [CW-1:0]   rd_ch;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            overflow;

    modport master (
        output din_dr, din_di, din_dv, din_chn, din_sample_k, ctrl_enable, ctrl_time_offset,
               done_ack, rd_bank, rd_ch, rd_addr, rd_en,
        input  done_req, done_bank, rd_data, rd_valid, overflow
    );
    modport slave (
        input  din_dr, din_di, din_dv, din_chn, din_sample_k, ctrl_enable, ctrl_time_offset,
               done_ack, rd_bank, rd_ch, rd_addr, rd_en,
        output done_req, done_bank, rd_data, rd_valid, overflow
    );
endinterface

// File: rtl/prach_buffer_mc.sv
// prach_buffer_mc: multi-channel PRACH window capture into ping-pong banks,
// with a done handshake per completed bank and a pipelined read port.
module prach_buffer_mc #(
    parameter int NUM_CH = 4,
    parameter int DW     = 16,
    parameter int DEPTH  = 1536,
    parameter int RD_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    prach_buffer_mc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
    typedef enum logic [1:0] {FREE, FILLING, READY} bank_t;

    state_t            state_q, state_d;
    bank_t             bank_q [2];
    bank_t             bank_d [2];
    logic [DW-1:0]     dr_q, di_q;
    logic              dv_q;
    logic [7:0]        chn_q;
    logic [15:0]       k_q, off_q, win_off_q, win_off_d;
    logic              wr_bank_q, wr_bank_d, done_bank_q, done_bank_d, ovf_q, ovf_d;
    logic [RD_LAT-1:0] rv_q, rv_d;
    logic [2*DW-1:0]   mem [2][NUM_CH][DEPTH];
    logic [2*DW-1:0]   rdp_q [RD_LAT];
    logic [15:0]       rel;
    logic              trig, last, wr_en, close, done_req, ack, wr_free;

    // In IDLE the index is taken against the pending offset so a dropped window is still recognised.
    assign rel      = k_q - (state_q == IDLE ? off_q : win_off_q);
    assign trig     = dv_q && chn_q == 8'd0 && rel == 16'd0;
    assign last     = dv_q && chn_q == 8'd0 && rel == 16'(DEPTH);
    assign wr_free  = bank_q[wr_bank_q] == FREE;
    assign done_req = bank_q[0] == READY || bank_q[1] == READY;
    assign ack      = bus.done_ack && done_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.ctrl_enable && wr_free ? ARMED : IDLE;
            ARMED:   state_d = trig ? CAPTURE : !bus.ctrl_enable ? IDLE : ARMED;
            CAPTURE: state_d = last ? IDLE : CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_off_d   = state_q == IDLE && state_d == ARMED ? off_q : win_off_q;
        wr_en       = (state_q == ARMED && trig) ||
                      (state_q == CAPTURE && dv_q && chn_q < 8'(NUM_CH) && rel < 16'(DEPTH));
        close       = state_q == CAPTURE && last;
        wr_bank_d   = wr_bank_q ^ close;
        done_bank_d = done_bank_q ^ ack;
        ovf_d       = state_q == IDLE && bus.ctrl_enable && !wr_free && trig;
        rv_d        = RD_LAT'({rv_q, bus.rd_en});
        for (int i = 0; i < 2; i++)
            bank_d[i] = ack && done_bank_q == 1'(i) ? FREE
                      : close && wr_bank_q == 1'(i) ? READY
                      : state_q == ARMED && trig && wr_bank_q == 1'(i) ? FILLING : bank_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]   <= FREE;
            bank_q[1]   <= FREE;
            dr_q        <= '0;
            di_q        <= '0;
            dv_q        <= 1'b0;
            chn_q       <= '0;
            k_q         <= '0;
            off_q       <= '0;
            win_off_q   <= '0;
            wr_bank_q   <= 1'b0;
            done_bank_q <= 1'b0;
            ovf_q       <= 1'b0;
            rv_q        <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            dr_q        <= bus.din_dr;
            di_q        <= bus.din_di;
            dv_q        <= bus.din_dv;
            chn_q       <= bus.din_chn;
            k_q         <= bus.din_sample_k;
            off_q       <= bus.ctrl_time_offset;
            win_off_q   <= win_off_d;
            wr_bank_q   <= wr_bank_d;
            done_bank_q <= done_bank_d;
            ovf_q       <= ovf_d;
            rv_q        <= rv_d;
        end
    end

    // Storage and read pipeline carry no reset; rd_data is gated by the reset-cleared valid pipe.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank_q][chn_q[CW-1:0]][rel[AW-1:0]] <= {di_q, dr_q};
        rdp_q[0] <= mem[bus.rd_bank][bus.rd_ch][bus.rd_addr];
        for (int i = 1; i < RD_LAT; i++) rdp_q[i] <= rdp_q[i-1];
    end

    assign bus.done_req  = done_req;
    assign bus.done_bank = done_bank_q;
    assign bus.overflow  = ovf_q;
    assign bus.rd_valid  = rv_q[RD_LAT-1];
    assign bus.rd_data   = rv_q[RD_LAT-1] ? rdp_q[RD_LAT-1] : '0;
endmodule

// File: doc/prach_buffer_mc.md
# prach_buffer_mc

Parametrised multi-channel PRACH capture buffer, the successor of the per-channel buffer. It captures a window of `DEPTH` samples for each of `NUM_CH` antenna channels, starting at a programmable sample offset. It stores the windows in a ping-pong pair of banks so the next PRACH occasion can be captured while the previous one is read out by the downstream FFT/correlator. A single done handshake reports each completed bank.

## Interface
Parameters:
- `NUM_CH`, 4: number of channels captured (1..16).
- `DW`, 16: width of each I/Q component.
- `DEPTH`, 1536: samples per channel per window (2..32768).
- `AW`, `$clog2(DEPTH)`: derived; not overridden.
- `CW`, `max(1,$clog2(NUM_CH))`: derived.
- `RD_LAT`, 3: read latency in cycles (≥1).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_dr`, `din_di` in `DW`: sample real and imag parts.
- `din_dv` in 1: sample valid.
- `din_chn` in 8: sample channel index.
- `din_sample_k` in 16: sample index, wraps modulo 2^16.
- `ctrl_enable` in 1: arm capture.
- `ctrl_time_offset` in 16: window start sample index.
- `done_req` out 1: a bank holds a complete window.
- `done_bank` out 1: bank referenced by `done_req`.
- `done_ack` in 1: releases `done_bank`.
- `rd_bank` in 1, `rd_ch` in `CW`, `rd_addr` in `AW`, `rd_en` in 1: read request.
- `rd_data` out `2*DW`: `{di,dr}`.
- `rd_valid` out 1: qualifies `rd_data`.
- `overflow` out 1: one-cycle pulse when a window is dropped.

## Operation
- Input stage: all `din_*` inputs and `ctrl_time_offset` are registered once.
- Offset arithmetic: `rel = din_sample_k − win_offset`, 16-bit modulo. A sample is in the window iff `rel < DEPTH`, evaluated without sign extension, so windows straddling the 0xFFFF→0 wrap are captured correctly.
- Channel order: samples arrive channel-interleaved, with channel 0 first for each `k`. Samples with `din_chn ≥ NUM_CH` are ignored.
- Bank states are FREE, FILLING and READY. `wr_bank` points to the bank being filled.
- Capture FSM states:
  - IDLE → ARMED when `ctrl_enable`=1 and bank `wr_bank` is FREE. On this transition `win_offset` latches the registered offset.
  - ARMED → CAPTURE on an accepted sample with `din_chn`=0 and `rel`=0. The bank becomes FILLING and the triggering sample is written.
  - In CAPTURE, every valid in-window sample is written to `mem[wr_bank][din_chn][rel]`.
  - CAPTURE → IDLE on an end marker (`din_dv`, `din_chn`=0, `rel`=`DEPTH`). The bank becomes READY and `wr_bank` toggles. The FSM re-arms next cycle if the conditions above hold.
- Overflow:
  - In IDLE with `ctrl_enable`=1 but bank `wr_bank` not FREE (both banks READY), a sample with `din_chn`=0 and `rel`=0 pulses `overflow`. That window is dropped entirely and the banks are untouched.
- Disable: deasserting `ctrl_enable` during CAPTURE does not abort the window. The FSM completes it and then stays in IDLE.
- Done queue:
  - `done_req`=1 whenever any bank is READY.
  - `done_bank` is the oldest READY bank.
  - `done_ack` is sampled only while `done_req`=1. It frees `done_bank`.
  - If the other bank is READY, `done_req` stays high and `done_bank` flips in the same cycle.
  - The reader finishes all reads of a bank before acking it.
- Read port:
  - Reads of FILLING or FREE banks return stale data; no error is flagged.
  - When `rd_en`=0, `rd_data` is 0.
- Reset: asynchronous. All state is cleared and both banks become FREE. Memory contents become don't-care.

## Timing
- Reset values: `done_req`=0, `done_bank`=0, `rd_data`=0, `rd_valid`=0, `overflow`=0. FSM is in IDLE and `wr_bank`=0.
- Write latency: a sample at input cycle t is written at the t+2 clock edge.
- Done latency: an end marker at input cycle t gives `done_req`=1 in cycle t+2.
- Ack latency: `done_ack` at cycle t drops `done_req` (or flips `done_bank`) at t+1.
- Re-capture: a freed bank is FREE at t+1 and can be ARMED at t+2.
- Read latency: `rd_en` at cycle t gives `rd_data`/`rd_valid` at t+`RD_LAT`. The port is fully pipelined, one read per cycle.
- Offset changes: a new `ctrl_time_offset` is registered at t+1 and takes effect only at the next IDLE→ARMED transition.
- Simultaneous events: an end marker and a `done_ack` for the other bank in the same cycle are both honoured.

## Test plan
- Basic capture:
  - Stimulus: `NUM_CH`=4, `DEPTH`=1536, offset 100; channel data is `{k,ch}`; read all four channels after `done_req`.
  - Response: every word equals its expected `{k,ch}` value; `done_bank`=0 and `done_req` rises exactly 2 cycles after the k=1636 marker.
- Wrap-around:
  - Stimulus: offset 0xFF00; stream `k` through 0xFFFF to 0x0500.
  - Response: address `rel`=0x100 holds sample k=0; all 1536 samples are captured.
- Ping-pong:
  - Stimulus: two back-to-back windows with no ack until both complete.
  - Response: `done_bank`=0 is reported, then after the ack `done_bank`=1 with `done_req` held high.
- Overflow:
  - Stimulus: a third window arrives while both banks are READY.
  - Response: one `overflow` pulse; bank contents are unchanged.
- Read pipeline:
  - Stimulus: `rd_en` pattern 1,0,1.
  - Response: `rd_valid` pattern 1,0,1 appears 3 cycles later; `rd_data` is 0 in the gap.
- Reset mid-capture:
  - Stimulus: assert `rst_n`=0 at `rel`=700.
  - Response: outputs go to 0 immediately; a subsequent window captures into bank 0.
